kbencode: RTL and testbench
===========================

# kbencode

Console keyboard encoder for the 2150 console typewriter path; the input-direction counterpart of the printer function decoder. It accepts single key strokes as 6-bit contact codes plus shift-key level, tracks keyboard case, and sequences shift-change, carrier-return and character cycles with the same cycle-time semantics the printer side uses. Each stroke produces an EBCDIC byte presented to the channel-side data register over a valid/ack handshake.

## Interface
- CYCLE_LEN, default 3: length in clocks of one mechanical cycle. Must be ≥1.
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_key_strobe  in  1  one-clock pulse: key pressed, i_key_code valid
- i_key_code  in  6  contact code of the key
- i_shift_key  in  1  shift key level, 1 = upper case requested
- i_return_key  in  1  one-clock pulse: carrier return key
- i_lock  in  1  keyboard locked by channel; strobes ignored
- i_data_ack  in  1  channel has taken o_data_reg
- o_data_reg  out  8  EBCDIC byte
- o_data_valid  out  1  o_data_reg holds an unread byte
- o_ready  out  1  FSM idle, stroke can be accepted
- o_cycle_time  out  1  character/CR cycle in progress
- o_shift_change  out  1  shift-change cycle in progress
- o_case_latch  out  1  current case, 1 = upper
- o_carrier_return_latch  out  1  CR cycle in progress
- o_overrun  out  1  one-clock pulse: stroke lost
- o_error  out  1  one-clock pulse: invalid key code

## Operation
- FSM states: IDLE, SHIFT, CYCLE, HOLD.
- IDLE (o_ready=1): strobe accepted if i_lock=0. i_return_key treated as code 37; if both pulse together, i_return_key wins, code ignored.
- Code map (lower case): 0–8 → 0x81–0x89 (a–i); 9–17 → 0x91–0x99 (j–r); 18–25 → 0xA2–0xA9 (s–z); 26–35 → 0xF0–0xF9; 36 → 0x40 (space); 37 → 0x15 (NL). Upper case: letters OR 0x40 (a 0x81 → A 0xC1); other codes unchanged.
- Codes 38–63: stroke dropped, o_error pulses, state stays IDLE, case unchanged.
- Valid stroke with i_shift_key ≠ o_case_latch → SHIFT; otherwise → CYCLE. i_shift_key and code captured at the accept edge.
- SHIFT: o_shift_change=1 for CYCLE_LEN clocks; o_case_latch toggles on exit; → CYCLE.
- CYCLE: o_cycle_time=1 for CYCLE_LEN clocks (2*CYCLE_LEN for NL, with o_carrier_return_latch=1 throughout). Exit loads o_data_reg using the post-shift case, sets o_data_valid → HOLD.
- HOLD: o_data_valid=1 until i_data_ack sampled high; then o_data_valid=0, → IDLE. i_data_ack outside HOLD ignored.
- Strobe while o_ready=0 and i_lock=0: dropped, o_overrun pulses (see Configuration).
- i_lock rising mid-stroke does not abort the stroke.
- Counter width sized for 2*CYCLE_LEN; counter reloads on every state entry.

## Timing
- Reset: state IDLE; o_data_reg=0x00, o_data_valid=0, o_ready=1, o_cycle_time=0, o_shift_change=0, o_case_latch=0, o_carrier_return_latch=0, o_overrun=0, o_error=0. Reset mid-stroke abandons the stroke, nothing presented.
- N = CYCLE_LEN, strobe sampled at edge T (o_ready drops at T+1).
- No shift: o_cycle_time high T+1..T+N; o_data_valid high from T+N+1.
- With shift: o_shift_change high T+1..T+N; o_case_latch new value from T+N+1; o_cycle_time high T+N+1..T+2N; o_data_valid from T+2N+1.
- NL: cycle phase 2N clocks, latency extended by N.
- Ack sampled at edge A: o_data_valid=0 and o_ready=1 from A+1; a strobe at A+1 is accepted.
- o_error / o_overrun: high exactly the clock after the offending strobe.

## Configuration
- KBENCODE_TYPEAHEAD_EN defined: one-entry typeahead buffer. Strobe while busy is stored (code, shift level, return flag) if buffer empty; o_overrun only when buffer full. On IDLE entry, buffered stroke is accepted that same clock (o_ready stays 0) and buffer clears. Invalid codes rejected at buffering time with o_error. i_lock does not flush the buffer.
- Undefined: no buffer; every strobe while busy → o_overrun.

## Test plan
- Reset, strobe code 0 with shift=0, N=3 → o_cycle_time T+1..T+3, o_data_reg=0x81, o_data_valid at T+4; ack → o_ready next clock.
- Strobe code 0 with shift=1 from lower case → o_shift_change 3 clocks, o_case_latch=1, byte 0xC1 at T+7; then code 26 shift=1 → 0xF0, no shift cycle.
- i_return_key → o_carrier_return_latch and o_cycle_time 6 clocks, byte 0x15; code 36 → 0x40.
- Code 50 → o_error pulse, no byte, o_ready stays 1; strobe with i_lock=1 → no activity.
- Strobe during CYCLE → o_overrun pulse (macro off); with KBENCODE_TYPEAHEAD_EN, second byte follows after first ack, third strobe → o_overrun.
- i_reset asserted mid-SHIFT → all outputs at reset values next clock, o_case_latch=0, no byte.

Source files
------------

// File: rtl/kbencode.sv
// kbencode: console keyboard encoder. Turns key strokes into EBCDIC bytes,
// sequencing shift-change, carrier-return and character cycles.
// Ports: i_clk, i_reset (sync, active-high); key inputs i_key_strobe,
// i_key_code[5:0], i_shift_key, i_return_key, i_lock; channel handshake
// i_data_ack / o_data_reg[7:0], o_data_valid; status o_ready,
// o_cycle_time, o_shift_change, o_case_latch, o_carrier_return_latch,
// o_overrun, o_error.
// Build option: define KBENCODE_TYPEAHEAD_EN for a one-entry typeahead buffer.
module kbencode #(
    parameter int CYCLE_LEN = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_key_strobe,
    input  logic [5:0] i_key_code,
    input  logic       i_shift_key,
    input  logic       i_return_key,
    input  logic       i_lock,
    input  logic       i_data_ack,
    output logic [7:0] o_data_reg,
    output logic       o_data_valid,
    output logic       o_ready,
    output logic       o_cycle_time,
    output logic       o_shift_change,
    output logic       o_case_latch,
    output logic       o_carrier_return_latch,
    output logic       o_overrun,
    output logic       o_error
);

    localparam int CW = $clog2(2 * CYCLE_LEN + 1);
    localparam logic [CW-1:0] LD1 = CW'(CYCLE_LEN - 1);
    localparam logic [CW-1:0] LD2 = CW'(2 * CYCLE_LEN - 1);
    localparam logic [5:0] NL_CODE = 6'd37;

    typedef enum logic [1:0] {IDLE, SHIFT, CYCLE, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    code_q;
    logic          nl_q;

    logic [5:0] in_code;
    logic       in_stroke;
    logic       in_valid;
    logic       go_idle;
    logic       go_buf;
    logic       go;
    logic [5:0] go_code;
    logic       go_shift;
    logic       go_nl;

`ifdef KBENCODE_TYPEAHEAD_EN
    logic       buf_v;
    logic [5:0] buf_code;
    logic       buf_shift;
`endif

    function automatic logic [7:0] enc(input logic [5:0] c, input logic up);
        logic [7:0] b;
        b = 8'h00;
        if (c <= 6'd8)
            b = 8'h81 + 8'(c);
        else if (c <= 6'd17)
            b = 8'h91 + 8'(c - 6'd9);
        else if (c <= 6'd25)
            b = 8'hA2 + 8'(c - 6'd18);
        else if (c <= 6'd35)
            b = 8'hF0 + 8'(c - 6'd26);
        else if (c == 6'd36)
            b = 8'h40;
        else if (c == NL_CODE)
            b = 8'h15;
        // Only letters have an upper-case form.
        if (up && c <= 6'd25)
            b = b | 8'h40;
        return b;
    endfunction

    always_comb begin
        // Carrier return takes priority over any simultaneous key code.
        in_code   = i_return_key ? NL_CODE : i_key_code;
        in_stroke = i_key_strobe | i_return_key;
        in_valid  = in_code <= NL_CODE;
        go_idle   = (state == IDLE) && in_stroke && !i_lock && in_valid;
`ifdef KBENCODE_TYPEAHEAD_EN
        go_buf    = (state == HOLD) && i_data_ack && buf_v;
        go_code   = go_buf ? buf_code : in_code;
        go_shift  = go_buf ? buf_shift : i_shift_key;
`else
        go_buf    = 1'b0;
        go_code   = in_code;
        go_shift  = i_shift_key;
`endif
        go        = go_idle | go_buf;
        go_nl     = go_code == NL_CODE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state                  <= IDLE;
            cnt                    <= '0;
            code_q                 <= '0;
            nl_q                   <= 1'b0;
            o_data_reg             <= 8'h00;
            o_data_valid           <= 1'b0;
            o_ready                <= 1'b1;
            o_cycle_time           <= 1'b0;
            o_shift_change         <= 1'b0;
            o_case_latch           <= 1'b0;
            o_carrier_return_latch <= 1'b0;
            o_overrun              <= 1'b0;
            o_error                <= 1'b0;
`ifdef KBENCODE_TYPEAHEAD_EN
            buf_v                  <= 1'b0;
            buf_code               <= '0;
            buf_shift              <= 1'b0;
`endif
        end else begin
            o_overrun <= 1'b0;
            o_error   <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_stroke && !i_lock && !in_valid)
                        o_error <= 1'b1;
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        state                  <= CYCLE;
                        o_case_latch           <= ~o_case_latch;
                        o_shift_change         <= 1'b0;
                        o_cycle_time           <= 1'b1;
                        o_carrier_return_latch <= nl_q;
                        cnt                    <= nl_q ? LD2 : LD1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CYCLE: begin
                    if (cnt == '0) begin
                        state                  <= HOLD;
                        // Case latch already reflects any shift cycle.
                        o_data_reg             <= enc(code_q, o_case_latch);
                        o_data_valid           <= 1'b1;
                        o_cycle_time           <= 1'b0;
                        o_carrier_return_latch <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (i_data_ack) begin
                        state        <= IDLE;
                        o_data_valid <= 1'b0;
                        o_ready      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Strokes arriving while busy.
            if (state != IDLE && in_stroke && !i_lock) begin
`ifdef KBENCODE_TYPEAHEAD_EN
                if (buf_v) begin
                    o_overrun <= 1'b1;
                end else if (!in_valid) begin
                    o_error <= 1'b1;
                end else begin
                    buf_v     <= 1'b1;
                    buf_code  <= in_code;
                    buf_shift <= i_shift_key;
                end
`else
                o_overrun <= 1'b1;
`endif
            end

`ifdef KBENCODE_TYPEAHEAD_EN
            if (go_buf)
                buf_v <= 1'b0;
`endif

            // Stroke start overrides the idle/hold transitions above.
            if (go) begin
                code_q  <= go_code;
                nl_q    <= go_nl;
                o_ready <= 1'b0;
                if (go_shift != o_case_latch) begin
                    state          <= SHIFT;
                    o_shift_change <= 1'b1;
                    cnt            <= LD1;
                end else begin
                    state                  <= CYCLE;
                    o_cycle_time           <= 1'b1;
                    o_carrier_return_latch <= go_nl;
                    cnt                    <= go_nl ? LD2 : LD1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kbencode.sv
// tb_kbencode: directed and random checks of kbencode against a
// behavioural model of the key-to-EBCDIC map and cycle timing.
module tb_kbencode;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_key_strobe = 1'b0;
    logic [5:0] i_key_code = '0;
    logic       i_shift_key = 1'b0;
    logic       i_return_key = 1'b0;
    logic       i_lock = 1'b0;
    logic       i_data_ack = 1'b0;
    logic [7:0] o_data_reg;
    logic       o_data_valid;
    logic       o_ready;
    logic       o_cycle_time;
    logic       o_shift_change;
    logic       o_case_latch;
    logic       o_carrier_return_latch;
    logic       o_overrun;
    logic       o_error;

    int n_chk = 0;
    int n_fail = 0;
    bit model_case = 1'b0;

    kbencode #(.CYCLE_LEN(N)) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_key_strobe(i_key_strobe),
        .i_key_code(i_key_code),
        .i_shift_key(i_shift_key),
        .i_return_key(i_return_key),
        .i_lock(i_lock),
        .i_data_ack(i_data_ack),
        .o_data_reg(o_data_reg),
        .o_data_valid(o_data_valid),
        .o_ready(o_ready),
        .o_cycle_time(o_cycle_time),
        .o_shift_change(o_shift_change),
        .o_case_latch(o_case_latch),
        .o_carrier_return_latch(o_carrier_return_latch),
        .o_overrun(o_overrun),
        .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Letters fall in EBCDIC rows 8/9/A of nine; row A starts at column 2.
    function automatic logic [7:0] ref_byte(input int code, input bit up);
        int row;
        int col;
        if (code < 26) begin
            row = code / 9;
            col = code % 9 + ((row == 2) ? 2 : 1);
            return 8'(8'h80 + 16 * row + col + (up ? 8'h40 : 0));
        end
        if (code < 36)
            return 8'(8'hF0 + code - 26);
        if (code == 36)
            return 8'h40;
        return 8'h15;
    endfunction

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (o_data_valid !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < 60), 1);
    endtask

    task automatic ack(input string tag, input bit exp_ready);
        i_data_ack = 1'b1;
        tick();
        i_data_ack = 1'b0;
        chk({tag, "_dv0"}, o_data_valid, 0);
        chk({tag, "_rdy"}, o_ready, 32'(exp_ready));
    endtask

    task automatic do_stroke(input int code, input bit sh, input bit ret);
        int eff;
        int sh_n;
        int cy_n;
        int k;
        int sc;
        int ct;
        int cr;
        int first_ct;
        eff  = ret ? 37 : code;
        sh_n = (sh != model_case) ? N : 0;
        cy_n = (eff == 37) ? 2 * N : N;
        chk("rdy_pre", o_ready, 1);
        i_key_strobe = ret ? 1'($urandom_range(0, 1)) : 1'b1;
        i_return_key = ret;
        i_key_code   = 6'(code);
        i_shift_key  = sh;
        tick();
        i_key_strobe = 1'b0;
        i_return_key = 1'b0;
        chk("rdy_drop", o_ready, 0);
        k = 1;
        sc = 0;
        ct = 0;
        cr = 0;
        first_ct = 0;
        while (o_data_valid !== 1'b1 && k < 60) begin
            sc += int'(o_shift_change);
            ct += int'(o_cycle_time);
            cr += int'(o_carrier_return_latch);
            if (o_cycle_time && first_ct == 0)
                first_ct = k;
            tick();
            k++;
        end
        chk("latency", k, sh_n + cy_n + 1);
        chk("shift_cyc", sc, sh_n);
        chk("cyc_time", ct, cy_n);
        chk("cr_cyc", cr, (eff == 37) ? cy_n : 0);
        chk("ct_start", first_ct, sh_n + 1);
        chk("ct_off", o_cycle_time, 0);
        chk("case", o_case_latch, 32'(sh));
        model_case = sh;
        chk("byte", o_data_reg, ref_byte(eff, model_case));
        ack("ack", 1'b1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_data", o_data_reg, 0);
        chk("rst_dv", o_data_valid, 0);
        chk("rst_rdy", o_ready, 1);
        chk("rst_ct", o_cycle_time, 0);
        chk("rst_sc", o_shift_change, 0);
        chk("rst_case", o_case_latch, 0);
        chk("rst_cr", o_carrier_return_latch, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_err", o_error, 0);
        i_reset = 1'b0;
        tick();

        // Directed strokes.
        do_stroke(0, 1'b0, 1'b0);
        do_stroke(0, 1'b1, 1'b0);
        do_stroke(26, 1'b1, 1'b0);
        do_stroke(0, 1'b1, 1'b1);
        do_stroke(36, 1'b1, 1'b0);
        do_stroke(25, 1'b0, 1'b0);

        // Invalid code.
        i_key_strobe = 1'b1;
        i_key_code   = 6'd50;
        i_shift_key  = ~model_case;
        tick();
        i_key_strobe = 1'b0;
        chk("err_pulse", o_error, 1);
        chk("err_rdy", o_ready, 1);
        chk("err_case", o_case_latch, 32'(model_case));
        tick();
        chk("err_clear", o_error, 0);
        chk("err_nodv", o_data_valid, 0);
        chk("err_nosc", o_shift_change, 0);

        // Locked keyboard.
        i_lock       = 1'b1;
        i_key_strobe = 1'b1;
        i_key_code   = 6'd5;
        tick();
        i_key_strobe = 1'b0;
        chk("lock_rdy", o_ready, 1);
        chk("lock_ct", o_cycle_time, 0);
        chk("lock_sc", o_shift_change, 0);
        tick();
        chk("lock_ct2", o_cycle_time, 0);
        i_lock = 1'b0;

        // Strobes while busy.
        i_key_strobe = 1'b1;
        i_key_code   = 6'd1;
        i_shift_key  = model_case;
        tick();
        i_key_code   = 6'd2;
        tick();
`ifdef KBENCODE_TYPEAHEAD_EN
        chk("buf_noovr", o_overrun, 0);
        i_key_code = 6'd3;
        tick();
        i_key_strobe = 1'b0;
        chk("buf_ovr", o_overrun, 1);
        tick();
        chk("buf_ovr_clr", o_overrun, 0);
        wait_valid("buf_v1");
        chk("buf_b1", o_data_reg, ref_byte(1, model_case));
        ack("buf_ack1", 1'b0);
        chk("buf_ct", o_cycle_time, 1);
        wait_valid("buf_v2");
        chk("buf_b2", o_data_reg, ref_byte(2, model_case));
        ack("buf_ack2", 1'b1);
`else
        i_key_strobe = 1'b0;
        chk("ovr_pulse", o_overrun, 1);
        tick();
        chk("ovr_clr", o_overrun, 0);
        wait_valid("ovr_v");
        chk("ovr_byte", o_data_reg, ref_byte(1, model_case));
        ack("ovr_ack", 1'b1);
        tick();
        chk("ovr_nomore", o_cycle_time, 0);
`endif

        // Lock rising mid-stroke does not abort.
        i_key_strobe = 1'b1;
        i_key_code   = 6'd30;
        i_shift_key  = model_case;
        tick();
        i_key_strobe = 1'b0;
        i_lock       = 1'b1;
        wait_valid("lock_mid_v");
        chk("lock_mid_b", o_data_reg, ref_byte(30, model_case));
        ack("lock_mid_ack", 1'b1);
        i_lock = 1'b0;

        // Reset in the middle of a shift cycle.
        if (model_case)
            do_stroke(4, 1'b0, 1'b0);
        i_key_strobe = 1'b1;
        i_key_code   = 6'd4;
        i_shift_key  = 1'b1;
        tick();
        i_key_strobe = 1'b0;
        tick();
        chk("mid_sc", o_shift_change, 1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        model_case = 1'b0;
        chk("mr_sc", o_shift_change, 0);
        chk("mr_case", o_case_latch, 0);
        chk("mr_rdy", o_ready, 1);
        chk("mr_dv", o_data_valid, 0);
        chk("mr_data", o_data_reg, 0);
        for (int i = 0; i < 2 * N + 2; i++)
            tick();
        chk("mr_nobyte", o_data_valid, 0);
        chk("mr_case2", o_case_latch, 0);

        // Random strokes against the model.
        for (int i = 0; i < 40; i++)
            do_stroke($urandom_range(0, 37), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
